// File: rtl/bwt_sort_arbiter.sv
// Round-robin arbiter sharing one BWT suffix-sort engine between NUM_REQ requesters.
// One job in flight at a time: IDLE -> START -> WAIT -> RESP -> IDLE; dbg_state exposes the FSM.
module bwt_sort_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STRING_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*STRING_LEN*8-1:0] req_string,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ack,
  output logic [STRING_LEN*8-1:0]         resp_bwt,
  output logic [STRING_LEN*8-1:0]         resp_suffix,
  output logic                            resp_err,
  output logic                            busy,
  output logic [15:0]                     jobs_done,
  output logic [STRING_LEN*8-1:0]         sorter_string,
  output logic                            sorter_start,
  input  logic                            sorter_done,
  input  logic [STRING_LEN*8-1:0]         sorter_bwt,
  input  logic [STRING_LEN*8-1:0]         sorter_suffix,
  output logic [1:0]                      dbg_state
);
  localparam int SW = STRING_LEN * 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW:0]   NUM_REQ_W  = (IW + 1)'(NUM_REQ);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   str_q, str_d;
  logic [SW-1:0]   bwt_q, bwt_d;
  logic [SW-1:0]   suf_q, suf_d;
  logic            err_q, err_d;
  logic [15:0]     jobs_q, jobs_d;

  logic [IW:0]     scan;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     idx_inc;
  logic [IW-1:0]   rr_next;

  // Scan rr_q, rr_q+1, ... (mod NUM_REQ) and take the first pending request.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_q} + (IW + 1)'(k);
      if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
      if (!pick_found && req[scan[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IW-1:0];
      end
    end
  end

  assign idx_inc = {1'b0, idx_q} + (IW + 1)'(1);
  assign rr_next = (idx_inc == NUM_REQ_W) ? '0 : idx_inc[IW-1:0];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rr_d         = rr_q;
    timer_d      = timer_q;
    str_d        = str_q;
    bwt_d        = bwt_q;
    suf_d        = suf_q;
    err_d        = err_q;
    jobs_d       = jobs_q;
    grant        = '0;
    resp_valid   = '0;
    sorter_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          str_d   = req_string[pick_idx*SW +: SW];
          state_d = S_START;
        end
      end
      S_START: begin
        grant[idx_q] = 1'b1;
        sorter_start = 1'b1;
        timer_d      = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last timer cycle still wins over the timeout.
        if (sorter_done) begin
          bwt_d   = sorter_bwt;
          suf_d   = sorter_suffix;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          bwt_d   = '0;
          suf_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        resp_valid[idx_q] = 1'b1;
        if (resp_ack[idx_q]) begin
          rr_d = rr_next;
          if (!err_q && jobs_q != 16'hFFFF) jobs_d = jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      str_q   <= '0;
      bwt_q   <= '0;
      suf_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      str_q   <= str_d;
      bwt_q   <= bwt_d;
      suf_q   <= suf_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  assign resp_bwt      = bwt_q;
  assign resp_suffix   = suf_q;
  assign resp_err      = err_q;
  assign busy          = (state_q != S_IDLE);
  assign jobs_done     = jobs_q;
  assign sorter_string = str_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_bwt_sort_arbiter.sv
// Bench for bwt_sort_arbiter: behavioural sort engine with programmable latency, a reference
// round-robin model over the pending-request mask, and an expected-result queue.
module tb_bwt_sort_arbiter;
  localparam int N  = 4;
  localparam int SL = 8;
  localparam int SW = SL * 8;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*SW-1:0] req_string = '0;
  logic [N-1:0]    grant, resp_valid;
  logic [N-1:0]    resp_ack = '0;
  logic [SW-1:0]   resp_bwt, resp_suffix;
  logic            resp_err, busy;
  logic [15:0]     jobs_done;
  logic [SW-1:0]   sorter_string;
  logic            sorter_start;
  logic            sorter_done = 1'b0;
  logic [SW-1:0]   sorter_bwt = '0, sorter_suffix = '0;
  logic [1:0]      dbg_state;

  bwt_sort_arbiter #(.NUM_REQ(N), .STRING_LEN(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_string(req_string), .grant(grant),
    .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_bwt(resp_bwt),
    .resp_suffix(resp_suffix), .resp_err(resp_err), .busy(busy), .jobs_done(jobs_done),
    .sorter_string(sorter_string), .sorter_start(sorter_start), .sorter_done(sorter_done),
    .sorter_bwt(sorter_bwt), .sorter_suffix(sorter_suffix), .dbg_state(dbg_state)
  );

  // ---------------- reference state ----------------
  int            n_cmp = 0;
  int            n_mis = 0;
  logic [N-1:0]  pend = '0;
  logic [SW-1:0] slice [N];
  int            rr_ref = 0;
  int            jobs_ref = 0;
  int            m_lat = 1;
  logic [SW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit suf_less(input logic [SW-1:0] s, input int a, input int b);
    for (int k = 0; k < SL; k++) begin
      if (a + k >= SL) return 1'b1;
      if (b + k >= SL) return 1'b0;
      if (s[(a+k)*8 +: 8] != s[(b+k)*8 +: 8]) return s[(a+k)*8 +: 8] < s[(b+k)*8 +: 8];
    end
    return 1'b0;
  endfunction

  // Suffix array by insertion sort; BWT char j is the char preceding suffix sa[j] (cyclic).
  function automatic void bwt_ref(input logic [SW-1:0] s, output logic [SW-1:0] bwt,
                                  output logic [SW-1:0] sa);
    int ord [SL];
    int t;
    for (int i = 0; i < SL; i++) ord[i] = i;
    for (int i = 1; i < SL; i++) begin
      for (int j = i; j > 0; j--) begin
        if (suf_less(s, ord[j], ord[j-1])) begin
          t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
        end
      end
    end
    for (int j = 0; j < SL; j++) begin
      sa[j*8 +: 8]  = 8'(ord[j]);
      bwt[j*8 +: 8] = s[((ord[j] + SL - 1) % SL)*8 +: 8];
    end
  endfunction

  function automatic int ref_pick();
    for (int k = 0; k < N; k++) if (pend[(rr_ref + k) % N]) return (rr_ref + k) % N;
    return -1;
  endfunction

  // ---------------- behavioural sort engine ----------------
  int            m_cnt = 0;
  bit            m_act = 1'b0;
  logic [SW-1:0] m_str = '0;
  always @(negedge clk) begin
    logic [SW-1:0] b, s;
    sorter_done   = 1'b0;
    sorter_bwt    = {$urandom, $urandom};
    sorter_suffix = {$urandom, $urandom};
    if (sorter_start) begin
      m_act = 1'b1;
      m_cnt = 0;
      m_str = sorter_string;
    end else if (m_act) begin
      m_cnt++;
      if (m_lat != 0 && m_cnt == m_lat) begin
        bwt_ref(m_str, b, s);
        sorter_done   = 1'b1;
        sorter_bwt    = b;
        sorter_suffix = s;
        m_act         = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req();
    for (int i = 0; i < N; i++) req_string[i*SW +: SW] = slice[i];
    req = pend;
  endtask

  task automatic add_req(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[i] && !pend[i]) begin
        slice[i] = {$urandom, $urandom};
        pend[i]  = 1'b1;
      end
    end
    drive_req();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req = '0;
    resp_ack = '0;
    repeat (cycles) @(negedge clk);
    check_eq("rst_ctrl", {grant, resp_valid, resp_err, busy, sorter_start, jobs_done}, '0);
    check_eq("rst_bwt", resp_bwt, '0);
    check_eq("rst_suffix", resp_suffix, '0);
    check_eq("rst_string", sorter_string, '0);
    rst = 1'b0;
    pend = '0;
    rr_ref = 0;
    jobs_ref = 0;
    exp_q.delete();
  endtask

  // Runs one job from an IDLE cycle (called at its negedge) back to IDLE.
  task automatic run_job(input int lat, input int ack_dly, input logic [N-1:0] mid_mask,
                         output int got_idx);
    int            exp_idx, k, exp_k;
    bit            exp_err, bad;
    logic [SW-1:0] eb, es;
    exp_idx = ref_pick();
    m_lat = lat;
    drive_req();
    @(negedge clk);
    got_idx = -1;
    for (int i = N - 1; i >= 0; i--) if (grant[i]) got_idx = i;
    check_eq("grant", grant, oh(exp_idx));
    check_eq("sorter_start", sorter_start, 1'b1);
    check_eq("sorter_string", sorter_string, slice[exp_idx]);
    exp_err = (lat == 0 || lat > TO);
    if (exp_err) begin
      eb = '0; es = '0;
    end else begin
      bwt_ref(slice[exp_idx], eb, es);
    end
    exp_q.push_back(eb);
    exp_q.push_back(es);
    pend[exp_idx] = 1'b0;
    drive_req();
    exp_k = exp_err ? TO + 1 : lat + 1;
    bad = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check_eq("start_pulse", {grant, sorter_start}, '0);
      else if (grant != '0) bad = 1'b1;
    end while (resp_valid == '0 && k < 300);
    check_eq("resp_latency", k, exp_k);
    check_eq("resp_valid", resp_valid, oh(exp_idx));
    check_eq("resp_err", resp_err, exp_err);
    eb = exp_q.pop_front();
    es = exp_q.pop_front();
    check_eq("resp_bwt", resp_bwt, eb);
    check_eq("resp_suffix", resp_suffix, es);
    add_req(mid_mask);
    for (int c = 0; c < ack_dly; c++) begin
      resp_ack = N'($urandom) & ~oh(exp_idx);
      @(negedge clk);
      if (resp_valid != oh(exp_idx) || resp_bwt != eb || resp_suffix != es ||
          resp_err != exp_err || grant != '0) bad = 1'b1;
    end
    resp_ack = oh(exp_idx) | N'($urandom);
    @(negedge clk);
    resp_ack = '0;
    if (!exp_err && jobs_ref < 16'hFFFF) jobs_ref++;
    rr_ref = (exp_idx + 1) % N;
    check_eq("idle_after_ack", {resp_valid, busy}, '0);
    check_eq("jobs_done", jobs_done, jobs_ref);
    check_eq("held_no_grant", bad, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int    g, r, lat;
    bit    bad;
    string banana;
    for (int i = 0; i < N; i++) slice[i] = '0;
    do_reset(2);

    // Basic job on requester 1 with "BANANA$\0".
    banana = "BANANA$";
    slice[1] = '0;
    for (int j = 0; j < 7; j++) slice[1][j*8 +: 8] = banana[j];
    pend = 4'b0010;
    run_job(20, 3, '0, g);
    check_eq("basic_idx", g, 1);
    check_eq("basic_jobs", jobs_done, 16'd1);

    // Round-robin order with all requesters pending.
    do_reset(1);
    for (int n = 0; n < 5; n++) begin
      add_req(4'b1111);
      run_job(2, 0, '0, g);
      check_eq("rr_order", g, n % N);
    end
    pend = '0;
    add_req(4'b0110);
    run_job(3, 0, '0, g);
    check_eq("rr_seq1", g, 1);
    run_job(3, 0, '0, g);
    check_eq("rr_seq2", g, 2);
    add_req(4'b1001);
    run_job(3, 0, '0, g);
    check_eq("rr_wrap3", g, 3);
    run_job(3, 0, '0, g);
    check_eq("rr_wrap0", g, 0);

    // Timeout: engine never answers.
    add_req(4'b0100);
    run_job(0, 1, '0, g);

    // Back-pressure on requester 3 with requester 2 waiting.
    add_req(4'b1000);
    run_job(15, 10, 4'b0100, g);
    check_eq("bp_first", g, 3);
    run_job(5, 0, '0, g);
    check_eq("bp_next", g, 2);

    // Done coincides with the last timer cycle.
    add_req(4'b0001);
    run_job(TO, 2, '0, g);

    // Reset while waiting; the engine's late done must be ignored.
    add_req(4'b0100);
    m_lat = 30;
    drive_req();
    @(negedge clk);
    check_eq("wait_rst_grant", grant, 4'b0100);
    pend = '0;
    drive_req();
    repeat (9) @(negedge clk);
    do_reset(1);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid != '0 || busy || grant != '0) bad = 1'b1;
    end
    check_eq("late_done_ignored", bad, 1'b0);
    add_req(4'b0101);
    run_job(4, 0, '0, g);
    check_eq("post_rst_first", g, 0);
    run_job(4, 0, '0, g);
    check_eq("post_rst_second", g, 2);

    // Randomized jobs.
    for (int n = 0; n < 40; n++) begin
      add_req(N'($urandom));
      if (pend == '0) add_req(oh($urandom_range(0, N - 1)));
      r = $urandom_range(0, 9);
      if (r == 0) lat = 0;
      else if (r == 1) lat = $urandom_range(60, 70);
      else lat = $urandom_range(1, 30);
      run_job(lat, $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
